// File: rtl/sdpram_port_arbiter.sv
// Three-requester arbiter for one port of the shared video/system RAM: requester 0 has fixed priority, 1 and 2 alternate round-robin.
// Latency: request-to-ack 1 cycle, request-to-read-data 2 cycles; ack, rvalid and the RAM port are registered, rdata is ram_q passed through.
// Backpressure: a requester holds req/we/addr/wdata until ack; no requester is granted on two consecutive cycles.
module sdpram_port_arbiter #(
    parameter int widthad_a = 10,
    parameter int width_a   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2:0]               req,
    input  logic [2:0]               we,
    input  logic [3*widthad_a-1:0]   addr,
    input  logic [3*width_a-1:0]     wdata,
    output logic [2:0]               ack,
    output logic [2:0]               rvalid,
    output logic [width_a-1:0]       rdata,
    output logic                     ram_wren,
    output logic [widthad_a-1:0]     ram_address,
    output logic [width_a-1:0]       ram_data,
    input  logic [width_a-1:0]       ram_q
);

    typedef enum logic {
        RR_ONE = 1'b0,
        RR_TWO = 1'b1
    } rr_t;

    rr_t                   rr_q;
    rr_t                   rr_d;
    logic [2:0]            elig;
    logic                  gnt_vld;
    logic [1:0]            gnt_sel;
    logic [2:0]            gnt_oh;
    logic                  sel_we;
    logic [widthad_a-1:0]  sel_addr;
    logic [width_a-1:0]    sel_wdata;

    // The requester acked this cycle sits out, which is what makes every requester starvation-free.
    assign elig = req & ~ack;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 2'd0;
        rr_d    = rr_q;
        if (elig[0]) begin
            gnt_vld = 1'b1;
            gnt_sel = 2'd0;
        end else if (elig[1] && elig[2]) begin
            gnt_vld = 1'b1;
            gnt_sel = (rr_q == RR_ONE) ? 2'd1 : 2'd2;
        end else if (elig[1]) begin
            gnt_vld = 1'b1;
            gnt_sel = 2'd1;
        end else if (elig[2]) begin
            gnt_vld = 1'b1;
            gnt_sel = 2'd2;
        end
        if (gnt_vld && gnt_sel == 2'd1) begin
            rr_d = RR_TWO;
        end else if (gnt_vld && gnt_sel == 2'd2) begin
            rr_d = RR_ONE;
        end
    end

    always_comb begin
        gnt_oh    = 3'b000;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (gnt_sel)
            2'd0: begin
                gnt_oh    = 3'b001;
                sel_we    = we[0];
                sel_addr  = addr[0*widthad_a +: widthad_a];
                sel_wdata = wdata[0*width_a +: width_a];
            end
            2'd1: begin
                gnt_oh    = 3'b010;
                sel_we    = we[1];
                sel_addr  = addr[1*widthad_a +: widthad_a];
                sel_wdata = wdata[1*width_a +: width_a];
            end
            2'd2: begin
                gnt_oh    = 3'b100;
                sel_we    = we[2];
                sel_addr  = addr[2*widthad_a +: widthad_a];
                sel_wdata = wdata[2*width_a +: width_a];
            end
            default: begin
                gnt_oh    = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= RR_ONE;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack         <= 3'b000;
            rvalid      <= 3'b000;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            // The RAM registers q at the end of the ack cycle, so the read returns one cycle after ack.
            rvalid <= ack & ~{3{ram_wren}};
            if (gnt_vld) begin
                ack         <= gnt_oh;
                ram_wren    <= sel_we;
                ram_address <= sel_addr;
                ram_data    <= sel_wdata;
            end else begin
                ack      <= 3'b000;
                ram_wren <= 1'b0;
            end
        end
    end

    assign rdata = ram_q;

endmodule

// File: tb/tb_sdpram_port_arbiter.sv
// Directed bench for sdpram_port_arbiter with a behavioural 1-cycle-latency RAM on the port.
module tb_sdpram_port_arbiter;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [29:0] addr;
    logic [23:0] wdata;
    logic [2:0]  ack;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic        ram_wren;
    logic [9:0]  ram_address;
    logic [7:0]  ram_data;
    logic [7:0]  ram_q;

    logic [7:0]  mem [0:1023];

    int checks;
    int failures;

    sdpram_port_arbiter #(.widthad_a(10), .width_a(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_wren    (ram_wren),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: registered q, read-before-write; a few locations preloaded while in reset.
    always @(posedge clock) begin
        if (reset) begin
            mem[10'h123] <= 8'h5A;
            mem[10'h010] <= 8'hA0;
            mem[10'h020] <= 8'hB1;
            mem[10'h030] <= 8'hC2;
            mem[10'h055] <= 8'hD3;
        end else if (ram_wren) begin
            mem[ram_address] <= ram_data;
        end
        ram_q <= mem[ram_address];
    end

    typedef struct {
        logic [2:0] rq;
        logic [2:0] w;
        logic [9:0] a0;
        logic [9:0] a1;
        logic [9:0] a2;
        logic [7:0] d;
        logic [2:0] e_ack;
        logic [2:0] e_rv;
        logic       e_wr;
        logic [9:0] e_ad;
        logic [7:0] e_dat;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] w,
                                input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                                input logic [7:0] d, input logic [2:0] e_ack, input logic [2:0] e_rv,
                                input logic e_wr, input logic [9:0] e_ad, input logic [7:0] e_dat,
                                input logic [7:0] e_rd);
        vec_t v;
        v.rq = rq; v.w = w; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d = d;
        v.e_ack = e_ack; v.e_rv = e_rv; v.e_wr = e_wr; v.e_ad = e_ad;
        v.e_dat = e_dat; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [2:0] rq, input logic [2:0] w,
                         input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                         input logic [7:0] d);
        req   = rq;
        we    = w;
        addr  = {a2, a1, a0};
        wdata = {d, d, d};
    endtask

    function automatic logic [7:0] rd_exp(input logic [2:0] oh);
        logic [7:0] r;
        r = 8'h00;
        if (oh == 3'b001) r = 8'hA0;
        if (oh == 3'b010) r = 8'hB1;
        if (oh == 3'b100) r = 8'hC2;
        return r;
    endfunction

    initial begin
        logic [2:0] exp_ack;
        logic [2:0] prev_ack;
        checks   = 0;
        failures = 0;

        tbl[0]  = mk(3'b010, 3'b000, 10'h000, 10'h123, 10'h000, 8'h00, 3'b010, 3'b000, 1'b0, 10'h123, 8'h00, 8'h00);
        tbl[1]  = mk(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 8'h00, 3'b000, 3'b010, 1'b0, 10'h123, 8'h00, 8'h5A);
        tbl[2]  = mk(3'b100, 3'b100, 10'h000, 10'h000, 10'h3FF, 8'hC3, 3'b100, 3'b000, 1'b1, 10'h3FF, 8'hC3, 8'h00);
        tbl[3]  = mk(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 8'h00, 3'b000, 3'b000, 1'b0, 10'h3FF, 8'h00, 8'h00);
        tbl[4]  = mk(3'b100, 3'b000, 10'h000, 10'h000, 10'h3FF, 8'h00, 3'b100, 3'b000, 1'b0, 10'h3FF, 8'h00, 8'h00);
        tbl[5]  = mk(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 8'h00, 3'b000, 3'b100, 1'b0, 10'h3FF, 8'h00, 8'hC3);
        tbl[6]  = mk(3'b001, 3'b001, 10'h02A, 10'h000, 10'h000, 8'h11, 3'b001, 3'b000, 1'b1, 10'h02A, 8'h11, 8'h00);
        for (int i = 7; i < 12; i++) begin
            tbl[i] = mk(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 8'h00, 3'b000, 3'b000, 1'b0, 10'h02A, 8'h00, 8'h00);
        end

        reset = 1'b1;
        drive(3'b000, 3'b000, 10'h0, 10'h0, 10'h0, 8'h00);
        step();
        step();
        chk("reset_ack", {29'd0, ack}, 32'd0);
        chk("reset_rvalid", {29'd0, rvalid}, 32'd0);
        chk("reset_wren", {31'd0, ram_wren}, 32'd0);
        chk("reset_address", {22'd0, ram_address}, 32'd0);
        chk("reset_data", {24'd0, ram_data}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rq, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d);
            step();
            chk($sformatf("vec%0d_ack", i), {29'd0, ack}, {29'd0, tbl[i].e_ack});
            chk($sformatf("vec%0d_rvalid", i), {29'd0, rvalid}, {29'd0, tbl[i].e_rv});
            chk($sformatf("vec%0d_wren", i), {31'd0, ram_wren}, {31'd0, tbl[i].e_wr});
            chk($sformatf("vec%0d_address", i), {22'd0, ram_address}, {22'd0, tbl[i].e_ad});
            if (tbl[i].e_wr) chk($sformatf("vec%0d_data", i), {24'd0, ram_data}, {24'd0, tbl[i].e_dat});
            if (tbl[i].e_rv != 3'b000) chk($sformatf("vec%0d_rdata", i), {24'd0, rdata}, {24'd0, tbl[i].e_rd});
        end

        // All three requesting continuously: 0 every other cycle, 1 and 2 alternating in between.
        drive(3'b111, 3'b000, 10'h010, 10'h020, 10'h030, 8'h00);
        prev_ack = 3'b000;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c % 2 == 1) exp_ack = 3'b001;
            else exp_ack = ((c / 2) % 2 == 1) ? 3'b010 : 3'b100;
            chk($sformatf("all3_c%0d_ack", c), {29'd0, ack}, {29'd0, exp_ack});
            chk($sformatf("all3_c%0d_rvalid", c), {29'd0, rvalid}, {29'd0, prev_ack});
            if (prev_ack != 3'b000) chk($sformatf("all3_c%0d_rdata", c), {24'd0, rdata}, {24'd0, rd_exp(prev_ack)});
            prev_ack = exp_ack;
        end
        drive(3'b000, 3'b000, 10'h010, 10'h020, 10'h030, 8'h00);
        step();
        chk("all3_tail_ack", {29'd0, ack}, 32'd0);
        chk("all3_tail_rvalid", {29'd0, rvalid}, 32'b100);
        chk("all3_tail_rdata", {24'd0, rdata}, 32'hC2);

        // Requesters 1 and 2 only: strict alternation with no idle cycles.
        drive(3'b110, 3'b000, 10'h010, 10'h020, 10'h030, 8'h00);
        prev_ack = 3'b000;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_ack = (c % 2 == 1) ? 3'b010 : 3'b100;
            chk($sformatf("pair_c%0d_ack", c), {29'd0, ack}, {29'd0, exp_ack});
            chk($sformatf("pair_c%0d_rvalid", c), {29'd0, rvalid}, {29'd0, prev_ack});
            if (prev_ack != 3'b000) chk($sformatf("pair_c%0d_rdata", c), {24'd0, rdata}, {24'd0, rd_exp(prev_ack)});
            prev_ack = exp_ack;
        end
        drive(3'b000, 3'b000, 10'h010, 10'h020, 10'h030, 8'h00);
        step();
        chk("pair_tail_rvalid", {29'd0, rvalid}, 32'b100);

        // Leave rr pointing at 2, then reset during a read ack; rr must come back as 1.
        drive(3'b010, 3'b000, 10'h055, 10'h020, 10'h030, 8'h00);
        step();
        chk("pre_rst_ack1", {29'd0, ack}, 32'b010);
        drive(3'b001, 3'b000, 10'h055, 10'h020, 10'h030, 8'h00);
        step();
        chk("pre_rst_ack0", {29'd0, ack}, 32'b001);
        chk("pre_rst_rvalid", {29'd0, rvalid}, 32'b010);
        reset = 1'b1;
        drive(3'b000, 3'b000, 10'h055, 10'h020, 10'h030, 8'h00);
        step();
        chk("midrst_rvalid", {29'd0, rvalid}, 32'd0);
        chk("midrst_ack", {29'd0, ack}, 32'd0);
        chk("midrst_wren", {31'd0, ram_wren}, 32'd0);
        chk("midrst_address", {22'd0, ram_address}, 32'd0);
        reset = 1'b0;
        drive(3'b110, 3'b000, 10'h055, 10'h020, 10'h030, 8'h00);
        step();
        chk("postrst_ack", {29'd0, ack}, 32'b010);
        chk("postrst_address", {22'd0, ram_address}, 32'h020);
        drive(3'b000, 3'b000, 10'h055, 10'h020, 10'h030, 8'h00);
        step();
        chk("postrst_rvalid", {29'd0, rvalid}, 32'b010);
        chk("postrst_rdata", {24'd0, rdata}, 32'hB1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdpram_port_arbiter.md
# sdpram_port_arbiter

Three-requester arbiter that shares one port of the dual-port video/system RAM between independent masters: requester 0 is the video fetch, requesters 1 and 2 are the CPU and the DMA/disk engine. It grants at most one access per clock, drives the RAM port with registered address, data and write-enable, and returns read data with a per-requester valid strobe. Requester 0 has fixed priority. Requesters 1 and 2 alternate round-robin. No requester can be granted on two consecutive cycles, so all requesters are starvation-free.

## Interface
Parameters:
- widthad_a, 10, RAM address width
- width_a, 8, RAM data width

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  3  access request per requester; bit i = requester i
- we  in  3  1 = write, 0 = read; qualified by req[i]
- addr  in  3*widthad_a  packed addresses; requester i at [i*widthad_a +: widthad_a]
- wdata  in  3*width_a  packed write data; requester i at [i*width_a +: width_a]
- ack  out  3  one-hot, registered; access of requester i is on the RAM port this cycle
- rvalid  out  3  one-hot, registered; read data for requester i is on rdata this cycle
- rdata  out  width_a  read data, equal to ram_q; meaningful only when rvalid is nonzero
- ram_wren  out  1  to RAM port wren
- ram_address  out  widthad_a  to RAM port address
- ram_data  out  width_a  to RAM port data
- ram_q  in  width_a  from RAM port q; registered in the RAM, 1-cycle read latency

## Operation
- Eligibility, evaluated at each rising edge: elig[i] = req[i] & ~ack[i]. The requester currently being acked is excluded.
- Selection:
  - If elig[0] = 1, grant 0.
  - Otherwise, if elig[1] and elig[2] are both 1, grant the requester named by the round-robin pointer rr.
  - Otherwise, grant whichever of elig[1] or elig[2] is set.
  - If no requester is eligible, there is no grant.
- rr update: rr <= 2 after granting 1, and rr <= 1 after granting 2. rr is unchanged after granting 0 or after no grant.
- On a grant to requester i, these are registered:
  - ack <= one-hot(i)
  - ram_wren <= we[i]
  - ram_address <= addr[i]
  - ram_data <= wdata[i]
- On no grant:
  - ack <= 0 and ram_wren <= 0.
  - ram_address and ram_data hold their previous values.
- Read return: rvalid <= ack & ~{3{ram_wren}}. rdata is ram_q passed through combinationally.
- A write returns nothing. The RAM's write-through value on q is ignored.
- Requester contract:
  - Hold req, we, addr and wdata stable from assertion until ack is seen.
  - Deassert req on the edge that ends the ack cycle, or keep it high to request another access. A req still high at the edge after the ack cycle counts as a new request.
- Reset is synchronous and takes priority over all other logic:
  - ack = 0, rvalid = 0, ram_wren = 0, ram_address = 0, ram_data = 0, rr = 1.
  - A read acked in the cycle before reset produces no rvalid.

## Timing
- Edge E0 samples req[i] and grants it. In cycle C1, ack[i] = 1 and the RAM port carries the access.
- Edge E1 is when the RAM performs the access. In cycle C2, rvalid[i] = 1 for a read, with rdata = mem[addr].
- Latency is request-to-ack 1 cycle and request-to-read-data 2 cycles, with no contention.
- Throughput is 1 access per cycle in aggregate and at most 1 access per 2 cycles per requester.
- Worst-case wait for requester 1 or 2 with all three requesting continuously is 3 cycles from req to ack.
- ack and rvalid are each one-hot or zero. They may both be nonzero in the same cycle for different accesses; this is pipelined operation.
- All outputs are registered except rdata.

## Test plan
- Single read: mem[0x123] = 0x5A, req = 3'b010, we = 0, addr1 = 0x123 held until ack → ack = 3'b010 in the next cycle with ram_address = 0x123 and ram_wren = 0; rvalid = 3'b010 and rdata = 0x5A the cycle after.
- Write then read: requester 2 writes 0xC3 to 0x3FF, then reads 0x3FF → ram_wren = 1 with ram_data = 0xC3 during its ack; no rvalid for the write; the read returns 0xC3.
- All three requests held high continuously for 12 cycles → ack sequence 001, 010, 001, 100, 001, 010, … Requester 0 gets every other cycle, and 1 and 2 alternate in the remaining cycles.
- Requesters 1 and 2 only, held high → acks alternate 010, 100, 010, … with no idle cycles; each requester has gaps of exactly 1 cycle; rr toggles every grant.
- Reset asserted in the cycle a read is acked → the next cycle has rvalid = 0, ack = 0, ram_wren = 0 and ram_address = 0. After release with req = 3'b110, requester 1 is granted first (rr = 1).
- Idle: req = 0 for 5 cycles after an access to 0x2A → ack = 0, ram_wren = 0, and ram_address holds 0x2A throughout.
